// File: rtl/mxfp8_pkg.sv
// Shared MXFP8 (E5M2 + E8M0 scale) types and constants.
// Block layout is {scale, elements[31:0]} with element 0 in the low byte.
package mxfp8_pkg;

  localparam int K_BLK = 32;
  localparam int size = 8 + 8 * K_BLK;

  localparam int E5M2_BIAS = 15;
  localparam int E5M2_EMAX = 15;
  localparam logic [6:0] E5M2_MAXNORM = 7'h7B;
  localparam logic [7:0] MX_SCALE_NAN = 8'hFF;

  typedef logic [7:0] mxfp8_e5m2_element;

  typedef struct packed {
    logic [7:0] scale;
    mxfp8_e5m2_element [K_BLK-1:0] elements;
  } mxfp8_block;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_QUANT,
    ST_EMIT
  } pk_state_e;

  // Shared exponent that puts the block maximum at the top E5M2 binade.
  function automatic logic [7:0] mx_scale(input logic [7:0] max_exp);
    if (max_exp > 8'(E5M2_EMAX))
      return max_exp - 8'(E5M2_EMAX);
    return 8'h00;
  endfunction

endpackage

// File: rtl/mxfp8_e5m2_quant.sv
// FP32 -> E5M2 under a shared E8M0 scale, round-to-nearest-even.
// Overflow saturates to max normal; FP32 subnormals flush to signed zero.
module mxfp8_e5m2_quant
  import mxfp8_pkg::*;
(
  input  logic [31:0]       fp32,
  input  logic [7:0]        scale,
  output mxfp8_e5m2_element q
);

  logic              sgn;
  logic [7:0]        e_fp;
  logic [23:0]       sig;
  logic [23:0]       sig_sh;
  logic [23:0]       lost_mask;
  logic signed [10:0] t;
  logic [4:0]        sh;
  logic [4:0]        base;
  logic [2:0]        kept;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [3:0]        sum;
  logic [7:0]        code;

  always_comb begin
    sgn  = fp32[31];
    e_fp = fp32[30:23];
    sig  = {1'b1, fp32[22:0]};
    t    = $signed({3'b000, e_fp}) - $signed({3'b000, scale})
         + $signed(11'(E5M2_BIAS));

    if (t >= 11'sd1)
      sh = 5'd0;
    else if (t < -11'sd22)
      sh = 5'd24;
    else
      sh = 5'(11'sd1 - t);

    sig_sh    = sig >> sh;
    lost_mask = (24'd1 << sh) - 24'd1;
    kept      = sig_sh[23:21];
    guard     = sig_sh[20];
    sticky    = (|sig_sh[19:0]) | (|(sig & lost_mask));
    rnd       = guard & (sticky | kept[0]);
    sum       = {1'b0, kept} + {3'b000, rnd};

    // Subnormals use base 1 so a round-up to 1.00 lands on exp field 1.
    base = (t >= 11'sd1) ? t[4:0] : 5'd1;
    code = {1'b0, base, 2'b00} + {4'b0000, sum} - 8'd4;

    if (scale == MX_SCALE_NAN)
      q = 8'h00;
    else if (e_fp == 8'h00)
      q = {sgn, 7'h00};
    else if (t > 11'sd30 || code > {1'b0, E5M2_MAXNORM})
      q = {sgn, E5M2_MAXNORM};
    else
      q = {sgn, code[6:0]};
  end

endmodule

// File: rtl/mxfp8_block_packer.sv
// Streams FP32 in, packs 32-element MXFP8 E5M2 blocks out.
// MXFP8_PACKER_FLUSH_EN: in_last_i closes a partial block early.
module mxfp8_block_packer
  import mxfp8_pkg::*;
#(
  parameter int K = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_data_i,
  input  logic            in_last_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [size-1:0] out_block_o
);

  localparam int IW = $clog2(K);

`ifdef MXFP8_PACKER_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  pk_state_e state_q, state_d;

  logic [IW:0]   cnt_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    max_exp_q;
  logic          special_q;
  logic [31:0]   buf_q [K];

  mxfp8_e5m2_element [K-1:0] stage_q;
  mxfp8_e5m2_element [K-1:0] stage_nx;
  mxfp8_block                out_q;

  logic              accept;
  logic              fill_done;
  logic              quant_done;
  logic [7:0]        in_exp;
  logic [7:0]        scale;
  logic [31:0]       q_src;
  mxfp8_e5m2_element q_elem;

  assign in_exp = in_data_i[30:23];
  assign accept = in_valid_i & ~reset_i
                & (state_q == ST_COLLECT);
  assign fill_done = accept
    & ((cnt_q == (IW+1)'(K-1)) | (in_last_i & FLUSH_EN));
  assign quant_done = (idx_q == IW'(K-1));

  assign scale = special_q ? MX_SCALE_NAN
                           : mx_scale(max_exp_q);

  // Slots past the fill count read as +0.
  assign q_src = ({1'b0, idx_q} < cnt_q) ? buf_q[idx_q]
                                         : 32'h0;

  mxfp8_e5m2_quant u_quant (
    .fp32  (q_src),
    .scale (scale),
    .q     (q_elem)
  );

  always_comb begin
    stage_nx = stage_q;
    stage_nx[idx_q] = q_elem;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_q <= ST_COLLECT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        in_ready_o = ~reset_i;
        if (fill_done)
          state_d = ST_QUANT;
      end
      ST_QUANT: begin
        if (quant_done)
          state_d = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid_o = 1'b1;
        if (out_ready_i)
          state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept)
      buf_q[cnt_q[IW-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      max_exp_q <= 8'h00;
      special_q <= 1'b0;
      out_q     <= '0;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          idx_q <= '0;
          if (accept) begin
            cnt_q <= cnt_q + (IW+1)'(1);
            if (in_exp == 8'hFF)
              special_q <= 1'b1;
            else if (in_exp > max_exp_q)
              max_exp_q <= in_exp;
          end
        end
        ST_QUANT: begin
          stage_q <= stage_nx;
          idx_q   <= idx_q + IW'(1);
          if (quant_done)
            out_q <= {scale, stage_nx};
        end
        ST_EMIT: begin
          if (out_ready_i) begin
            cnt_q     <= '0;
            max_exp_q <= 8'h00;
            special_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_block_o = out_q;

endmodule
